if_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the 5-stage pipeline IF stage. Owns the fetch PC and drives the synchronous instruction SRAM. Buffers returned instructions in a 2-entry skid FIFO so ID back-pressure (stall) never loses a fetch. Takes branch/jump redirects from EX, discarding wrong-path fetches.

---
 rtl/if_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_if_fetch_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, drives the instruction
// SRAM and buffers returned words in a 2-entry skid FIFO for ID.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] issued_pc_q, issued_pc_d;
    logic        inflight_q, inflight_d;
    logic        killed_q, killed_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] fifo_pc_q   [2];
    logic [31:0] fifo_inst_q [2];

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occ;
    logic        unused_rpc_lsbs;

    // Word alignment discards the low bits of the redirect target.
    assign unused_rpc_lsbs = ^redirect_pc_i[1:0];

    // Head visibility, pop/push qualification and issue decision.
    always_comb begin
        if_valid = (count_q != 2'd0) && !rst;
        pop      = if_valid && !stall_i && !redirect_i;
        push     = inflight_q && !killed_q && !redirect_i;
        occ      = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        issue    = (state_q == RUN) && !redirect_i && !rst
                   && (occ < 3'd2);
    end

    assign inst_sram_en   = issue;
    assign inst_sram_addr = fetch_pc_q;
    assign if_pc          = if_valid ? fifo_pc_q[rd_ptr_q]   : 32'd0;
    assign if_inst        = if_valid ? fifo_inst_q[rd_ptr_q] : 32'd0;

    // FSM next state: BOOT holds off the SRAM for one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Fetch PC, in-flight tracking and FIFO bookkeeping.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = issue;
        killed_d    = redirect_i && inflight_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
        end else begin
            if (issue) begin
                issued_pc_d = fetch_pc_q;
                fetch_pc_d  = fetch_pc_q + 32'd4;
            end
            count_d = count_q + 2'(push) - 2'(pop);
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= RESET_PC;
            inflight_q  <= 1'b0;
            killed_q    <= 1'b0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            killed_q    <= killed_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // Skid FIFO storage; contents are only visible through count_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_pc_q[wr_ptr_q]   <= issued_pc_q;
            fifo_inst_q[wr_ptr_q] <= inst_sram_rdata;
        end
    end

    // The occupancy rule must keep the skid FIFO from overflowing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= 2'd2);
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: boot, stall, redirect, PC wrap
// and mid-stream reset, with an SRAM that returns the address as data.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int nvec = 0;
    int nmis = 0;

    if_fetch_ctrl #(.RESET_PC(32'h00000000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model: data = address, one cycle after enable.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= inst_sram_addr;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n, input logic e_en,
                       input logic [31:0] e_addr, input logic e_v,
                       input logic [31:0] e_pc, input logic [31:0] e_inst);
        #1;
        chk($sformatf("c%0d.en", n),   32'(inst_sram_en), 32'(e_en));
        chk($sformatf("c%0d.addr", n), inst_sram_addr, e_addr);
        chk($sformatf("c%0d.vld", n),  32'(if_valid), 32'(e_v));
        chk($sformatf("c%0d.pc", n),   if_pc, e_pc);
        chk($sformatf("c%0d.inst", n), if_inst, e_inst);
        tick();
    endtask

    initial begin
        inst_sram_rdata = 32'hDEADBEEF;
        rst = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'd0;
        tick();
        tick();
        rst = 1'b0;

        // Boot and streaming
        cyc(1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc(2, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc(3, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(4 + k, 1'b1, 32'(8 + 4 * k), 1'b1,
                32'(4 * k), 32'(4 * k));
        end

        // Stall for five cycles
        stall_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(8 + k, 1'b0, 32'd24, 1'b1, 32'd16, 32'd16);
        end
        stall_i = 1'b0;
        cyc(13, 1'b1, 32'd24, 1'b1, 32'd16, 32'd16);
        cyc(14, 1'b1, 32'd28, 1'b1, 32'd20, 32'd20);
        cyc(15, 1'b1, 32'd32, 1'b1, 32'd24, 32'd24);

        // Redirect with a fetch in flight
        redirect_i = 1'b1;
        redirect_pc_i = 32'h00000103;
        cyc(16, 1'b0, 32'd36, 1'b1, 32'd28, 32'd28);
        redirect_i = 1'b0;
        cyc(17, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        cyc(18, 1'b1, 32'h104, 1'b0, 32'h0, 32'h0);
        cyc(19, 1'b1, 32'h108, 1'b1, 32'h100, 32'h100);

        // Redirect during stall with full FIFO, target near the top
        stall_i = 1'b1;
        cyc(20, 1'b0, 32'h10C, 1'b1, 32'h104, 32'h104);
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFFFFF8;
        cyc(21, 1'b0, 32'h10C, 1'b1, 32'h104, 32'h104);
        redirect_i = 1'b0;
        stall_i = 1'b0;
        cyc(22, 1'b1, 32'hFFFFFFF8, 1'b0, 32'h0, 32'h0);
        cyc(23, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 32'h0);
        cyc(24, 1'b1, 32'h0, 1'b1, 32'hFFFFFFF8, 32'hFFFFFFF8);
        cyc(25, 1'b1, 32'h4, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC);

        // Reset mid-stream with a fetch in flight
        rst = 1'b1;
        #1;
        chk("c26.en",  32'(inst_sram_en), 32'd0);
        chk("c26.vld", 32'(if_valid), 32'd0);
        chk("c26.pc",  if_pc, 32'd0);
        tick();
        rst = 1'b0;
        cyc(27, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc(28, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc(29, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
        cyc(30, 1'b1, 32'h8, 1'b1, 32'h0, 32'h0);
        cyc(31, 1'b1, 32'hC, 1'b1, 32'h4, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
